// File: rtl/mips_defs.sv
// mips_defs: shared datapath constants and the IF/ID register layout
package mips_defs;
  localparam int DATA_WIDTH = 32;
  typedef logic [DATA_WIDTH-1:0] word_t;
  localparam word_t NOP_INSTR = 32'h0;
  localparam word_t WORD_BYTES = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0004;
  localparam word_t DEFAULT_IMEM_SIZE = 32'h0000_0800;
  typedef struct packed {
    word_t instruction;
    word_t pc_plus4;
    logic valid;
  } if_id_t;
  localparam if_id_t BUBBLE = '{instruction: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next-pc selection, bubble decision and misaligned-redirect detection
module fetch_next_pc
  import mips_defs::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t IMEM_SIZE = DEFAULT_IMEM_SIZE
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic        load_bubble,
  output logic        misaligned
);
  logic [32:0] pc_ext;
  logic [32:0] lo_ext;
  logic [32:0] hi_ext;
  logic        out_of_range;
  assign pc_ext = {1'b0, pc};
  assign lo_ext = {1'b0, RESET_PC};
  assign hi_ext = {1'b0, RESET_PC} + {1'b0, IMEM_SIZE};
  assign out_of_range = (pc_ext < lo_ext) || (pc_ext >= hi_ext);
  assign next_pc = redirect ? {redirect_target[31:2], 2'b00} : stall ? pc : pc + WORD_BYTES;
  assign load_bubble = redirect || (!stall && out_of_range);
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: mips fetch stage holding pc, if/id register, sticky fault and fetch counter
module fetch_unit
  import mips_defs::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t IMEM_SIZE = DEFAULT_IMEM_SIZE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);
  if_id_t      if_id;
  logic [31:0] next_pc;
  logic        load_bubble;
  logic        misaligned;
  logic        hold;
  logic        range_fault;
  fetch_next_pc #(.RESET_PC(RESET_PC), .IMEM_SIZE(IMEM_SIZE)) u_next (
    .pc              (pc),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .load_bubble     (load_bubble),
    .misaligned      (misaligned)
  );
  assign hold = stall && !redirect;
  assign range_fault = load_bubble && !redirect;
  assign imem_address = pc;
  assign if_id_instruction = if_id.instruction;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_valid = if_id.valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      if_id <= BUBBLE;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      pc <= next_pc;
      fetch_fault <= fetch_fault || misaligned || range_fault;
      if (!hold) if_id <= load_bubble ? BUBBLE : '{instruction: imem_instruction, pc_plus4: pc + WORD_BYTES, valid: 1'b1};
      if (!hold && !load_bubble) fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  int checks = 0;
  int errors = 0;
  fetch_unit dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .pc                (pc),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_fault       (fetch_fault),
    .fetch_count       (fetch_count)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  assign imem_instruction = word_at(imem_address);
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check_state(input string name, input logic [31:0] e_pc, input logic [31:0] e_ins,
                             input logic [31:0] e_pc4, input logic e_valid, input logic e_fault,
                             input logic [31:0] e_cnt);
    checks++;
    if (pc !== e_pc || imem_address !== e_pc || if_id_instruction !== e_ins || if_id_pc_plus4 !== e_pc4 ||
        if_id_valid !== e_valid || fetch_fault !== e_fault || fetch_count !== e_cnt) begin
      errors++;
      $display("FAIL %s: got pc=%h addr=%h ins=%h pc4=%h v=%b f=%b cnt=%0d expected pc=%h ins=%h pc4=%h v=%b f=%b cnt=%0d",
               name, pc, imem_address, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_fault, fetch_count,
               e_pc, e_ins, e_pc4, e_valid, e_fault, e_cnt);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    check_state("reset", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 0);
  endtask
  task automatic test_sequential();
    step();
    check_state("seq0", 32'h8, 32'h5A5A_0004, 32'h8, 1'b1, 1'b0, 1);
    step();
    check_state("seq1", 32'hC, 32'h5A5A_0008, 32'hC, 1'b1, 1'b0, 2);
    step();
    check_state("seq2", 32'h10, 32'h5A5A_000C, 32'h10, 1'b1, 1'b0, 3);
  endtask
  task automatic test_stall();
    stall = 1'b1;
    step();
    check_state("stall0", 32'h10, 32'h5A5A_000C, 32'h10, 1'b1, 1'b0, 3);
    step();
    check_state("stall1", 32'h10, 32'h5A5A_000C, 32'h10, 1'b1, 1'b0, 3);
    stall = 1'b0;
    step();
    check_state("stall_release", 32'h14, 32'h5A5A_0010, 32'h14, 1'b1, 1'b0, 4);
  endtask
  task automatic test_redirect();
    redirect = 1'b1;
    redirect_target = 32'h40;
    stall = 1'b1;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    check_state("redirect_flush", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 4);
    step();
    check_state("redirect_fetch", 32'h44, 32'h5A5A_0040, 32'h44, 1'b1, 1'b0, 5);
  endtask
  task automatic test_misaligned();
    redirect = 1'b1;
    redirect_target = 32'h42;
    step();
    redirect = 1'b0;
    check_state("misaligned", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 5);
    step();
    step();
    check_state("fault_sticky", 32'h48, 32'h5A5A_0044, 32'h48, 1'b1, 1'b1, 7);
  endtask
  task automatic test_range();
    do_reset();
    check_state("range_reset", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    redirect = 1'b1;
    redirect_target = 32'h7FC;
    step();
    redirect = 1'b0;
    step();
    check_state("range_last_m1", 32'h800, 32'h5A5A_07FC, 32'h800, 1'b1, 1'b0, 1);
    step();
    check_state("range_last", 32'h804, 32'h5A5A_0800, 32'h804, 1'b1, 1'b0, 2);
    step();
    check_state("range_over", 32'h808, 32'h0, 32'h0, 1'b0, 1'b1, 2);
  endtask
  task automatic test_wrap_low();
    do_reset();
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check_state("wrap", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    do_reset();
    redirect = 1'b1;
    redirect_target = 32'h0;
    step();
    redirect = 1'b0;
    check_state("low_redirect", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    step();
    check_state("below_base", 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    step();
    check_state("base_fetch", 32'h8, 32'h5A5A_0004, 32'h8, 1'b1, 1'b1, 1);
  endtask
  task automatic test_reset_override();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h102;
    reset = 1'b1;
    step();
    check_state("reset_override", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    step();
    check_state("after_reset", 32'h8, 32'h5A5A_0004, 32'h8, 1'b1, 1'b0, 1);
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_range();
    test_wrap_low();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
